div_tick_timer: RTL and testbench
=================================

Name: div_tick_timer

Overview:
Downstream consumer of the four divided clock levels produced by the mclk divider stage. It selects one divided clock and re-times it into the mclk domain. It converts each rising edge into a single-cycle tick enable. A programmable down-counting timer (one-shot or periodic) runs on those ticks, so downstream logic clocks on mclk only and never on the divided signals.

Parameters:
WIDTH, 16, width of timer load value and count.

Ports:
mclk  input  1  system clock; all state is on its rising edge
rst_n  input  1  asynchronous active-low reset
div_clk  input  4  divided clock levels, bit0 = fastest ... bit3 = slowest
sel  input  2  index of the div_clk bit used as tick source
start  input  1  level-sampled start request
stop  input  1  level-sampled abort request
mode  input  1  0 = one-shot, 1 = periodic auto-reload
load_val  input  WIDTH  timer period in ticks, captured on accepted start
tick  output  1  one-mclk-cycle pulse per rising edge of selected div_clk
busy  output  1  high while the timer is in RUN
done  output  1  one-mclk-cycle pulse at timer expiry
count  output  WIDTH  current remaining tick count

Behaviour:
- Reset (rst_n low, asynchronous): tick=0, busy=0, done=0, count=0, FSM=IDLE, sync flops=0, reload register=0, sel register=0, mode register=0.
- Source path:
  - div_clk[sel] passes through 2 sync flops (s1, s2), then an edge flop (s3).
  - tick is registered as s2 & ~s3.
  - div_clk[sel] high first sampled at mclk edge k -> tick high for exactly the cycle following edge k+2 (3-edge latency).
  - tick runs independently of the timer FSM, including in IDLE.
- sel is registered each cycle. On a change of registered sel, tick is forced 0 for 3 mclk cycles; no spurious edge from the switch.
- FSM states: IDLE, RUN.
  - IDLE + start=1 + stop=0:
    - load_val!=0: count<=load_val, reload<=load_val, mode latched, next state RUN, busy=1 from the next cycle.
    - load_val==0: done pulses next cycle, count stays 0, state stays IDLE.
  - RUN + stop=1: next state IDLE, count<=0, busy<=0, no done. stop has priority over tick and start.
  - RUN + tick + count>1: count<=count-1.
  - RUN + tick + count==1: done pulses next cycle.
    - Latched one-shot: count<=0, next state IDLE.
    - Latched periodic: count<=reload, stays RUN with no dead cycle.
  - RUN + start: ignored. load_val and mode changes have no effect until the next accepted start.
  - IDLE + stop: no effect.
- Ticks in IDLE do not change count.
- Count never wraps below 0.
- done and tick never stretch beyond 1 cycle.
- Reset asserted mid-RUN aborts immediately to reset values. No done on release.
- Arithmetic is unsigned WIDTH-bit. Maximum period is 2^WIDTH-1 ticks.

Test Plan:
- Reset: drive rst_n=0 mid-RUN with count=5 -> all outputs 0 within the same cycle (async). After release, tick is 0 until the first synced rising edge.
- Tick timing: free-running 16-bit counter drives div_clk={c[8],c[6],c[4],c[2]}, sel=0 -> tick every 8 mclk cycles, 3 cycles after each c[2] rise. sel=3 -> period 512.
- One-shot: sel=0, mode=0, load_val=3, pulse start -> busy=1, count steps 3,2,1,0 on successive ticks, done pulses once. Then busy=0 and IDLE; a further 10 ticks leave count=0.
- Periodic: mode=1, load_val=2, sel=1 -> done every 2 ticks (64 mclk cycles), count reloads 2 with no gap. Changing load_val to 5 mid-run has no effect. stop -> busy=0, count=0, no done.
- Boundaries:
  - start with load_val=0 -> single done, busy stays 0.
  - stop and tick in the same cycle with count=1 -> no done.
  - start while RUN -> count unaffected.
- sel switch: change sel 0->3 while selected bit is low and new bit is high -> no tick for 3 cycles. Next tick only on the next true rising edge of div_clk[3].

Source files
------------

// File: rtl/div_tick_timer.sv
// div_tick_timer
// Selects one of four divided clock levels, re-times it into the mclk domain,
// converts each rising edge into a one-cycle tick enable, and runs a
// programmable down-counting timer (one-shot or periodic) on those ticks.
// All state lives on mclk; the divided levels are only ever sampled as data.
module div_tick_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [3:0]       div_clk,
  input  logic [1:0]       sel,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Source selection and re-timing
  logic [1:0]       sel_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             edge_q;
  logic [1:0]       blank_q;
  logic [1:0]       blank_d;
  logic             tick_q;
  logic             tick_d;
  logic             sel_chg;
  logic             src_bit;

  // Timer
  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             mode_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;

  // Pick the source through the registered select and derive the tick.
  // A select change leaves old-source and new-source samples mixed in the
  // sync chain for three edges; the blanking window hides any false edge
  // that mix would produce, so the first tick afterwards is a real rise.
  always_comb begin
    sel_chg = (sel != sel_q);
    src_bit = div_clk[sel_q];
    if (sel_chg) begin
      blank_d = 2'd3;
    end else if (blank_q != 2'd0) begin
      blank_d = blank_q - 2'd1;
    end else begin
      blank_d = 2'd0;
    end
    tick_d = (blank_q == 2'd0) ? (sync2_q & ~edge_q) : 1'b0;
  end

  // Select register, two-flop synchroniser, edge flop and registered tick.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      blank_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      sel_q   <= sel;
      sync1_q <= src_bit;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

  // Timer FSM: accepts start in IDLE, counts ticks down in RUN, stop aborts.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (load_val == '0) begin
              // Zero period expires immediately without entering RUN.
              done_q <= 1'b1;
            end else begin
              state_q  <= RUN;
              busy_q   <= 1'b1;
              count_q  <= load_val;
              reload_q <= load_val;
              mode_q   <= mode;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else if (tick_q) begin
            if (count_q > WIDTH'(1)) begin
              count_q <= count_q - WIDTH'(1);
            end else begin
              done_q <= 1'b1;
              if (mode_q) begin
                count_q <= reload_q;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                count_q <= '0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign tick  = tick_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_div_tick_timer.sv
// Bench for div_tick_timer: randomized and directed stimulus checked against a
// behavioural model built from the tick latency / blanking rules and the timer
// rules, evaluated once per mclk edge.
module tb_div_tick_timer;

  localparam int unsigned WIDTH = 16;

  logic             mclk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       div_clk = '0;
  logic [1:0]       sel = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             tick;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [15:0] c = '0;
  bit use_cnt = 1'b1;

  // Reference model state
  bit               hist[$];
  logic [1:0]       m_sel = '0;
  bit               m_t;
  bit               e_tick = 1'b0;
  bit               e_busy = 1'b0;
  bit               e_done = 1'b0;
  logic [WIDTH-1:0] e_count = '0;
  logic [WIDTH-1:0] m_reload = '0;
  bit               m_periodic = 1'b0;

  always #5 mclk = ~mclk;

  div_tick_timer #(.WIDTH(WIDTH)) dut (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .div_clk (div_clk),
    .sel     (sel),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .load_val(load_val),
    .tick    (tick),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  // Model: a tick follows edge n when the source sampled at n-2 was high and
  // at n-3 was low, both samples coming from the current (registered) select.
  // Before the first edge after reset the source is taken to have been low.
  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      hist = '{1'b0, 1'b0, 1'b0};
      m_sel = '0;
      e_tick = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_count = '0;
      m_reload = '0;
      m_periodic = 1'b0;
    end else begin
      m_t = e_tick;
      e_done = 1'b0;
      if (!e_busy) begin
        if (start && !stop) begin
          if (load_val == 0) e_done = 1'b1;
          else begin
            e_busy = 1'b1;
            e_count = load_val;
            m_reload = load_val;
            m_periodic = mode;
          end
        end
      end else if (stop) begin
        e_busy = 1'b0;
        e_count = '0;
      end else if (m_t) begin
        if (e_count == 1) begin
          e_done = 1'b1;
          if (m_periodic) e_count = m_reload;
          else begin
            e_count = '0;
            e_busy = 1'b0;
          end
        end else begin
          e_count = e_count - 1;
        end
      end
      hist.push_back(div_clk[m_sel]);
      if (hist.size() > 4) void'(hist.pop_front());
      e_tick = (hist.size() == 4) && hist[1] && !hist[0];
      if (sel != m_sel) begin
        m_sel = sel;
        hist.delete();
      end
    end
  end

  task automatic step();
    @(posedge mclk);
    #1;
    cyc++;
    c = c + 16'd1;
    if (use_cnt) div_clk = {c[8], c[6], c[4], c[2]};
    else div_clk = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({tick, busy, done, count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state got tick=%b busy=%b done=%b count=%0d required all 0", tick, busy, done, count);
    end
    rst_n = 1'b1;
    step();
    sel = 2'd0; mode = 1'b0; load_val = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    tests_run++;
    if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count} || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_prerun got tick=%b busy=%b done=%b count=%0d exp tick=%b busy=1 done=%b count=%0d", tick, busy, done, count, e_tick, e_done, e_count);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({tick, busy, done, count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async got tick=%b busy=%b done=%b count=%0d required all 0", tick, busy, done, count);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      tests_run++;
      if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count}) begin
        tests_failed++;
        $display("FAIL reset_release cyc=%0d got tick=%b busy=%b done=%b count=%0d exp tick=%b busy=%b done=%b count=%0d", cyc, tick, busy, done, count, e_tick, e_busy, e_done, e_count);
      end
    end
  endtask

  task automatic test_tick_timing();
    int nticks;
    int t_first;
    int t_second;
    sel = 2'd0;
    repeat (8) step();
    nticks = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (tick === 1'b1) nticks++;
      tests_run++;
      if (tick !== e_tick) begin
        tests_failed++;
        $display("FAIL tick_sel0 cyc=%0d got tick=%b exp tick=%b", cyc, tick, e_tick);
      end
    end
    tests_run++;
    if (nticks != 8) begin
      tests_failed++;
      $display("FAIL tick_sel0_rate got %0d ticks in 64 cycles required 8", nticks);
    end
    sel = 2'd3;
    t_first = -1;
    t_second = -1;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (tick === 1'b1) begin
        if (t_first < 0) t_first = cyc;
        else if (t_second < 0) t_second = cyc;
      end
      tests_run++;
      if (tick !== e_tick) begin
        tests_failed++;
        $display("FAIL tick_sel3 cyc=%0d got tick=%b exp tick=%b", cyc, tick, e_tick);
      end
    end
    tests_run++;
    if (t_first < 0 || t_second < 0 || (t_second - t_first) != 512) begin
      tests_failed++;
      $display("FAIL tick_sel3_period got first=%0d second=%0d required spacing 512", t_first, t_second);
    end
  endtask

  task automatic test_one_shot();
    int ndone;
    int nticks;
    bit seen;
    sel = 2'd0;
    repeat (10) step();
    mode = 1'b0; load_val = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (done === 1'b1) begin
        ndone++;
        seen = 1'b1;
      end
      tests_run++;
      if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count}) begin
        tests_failed++;
        $display("FAIL oneshot cyc=%0d got tick=%b busy=%b done=%b count=%0d exp tick=%b busy=%b done=%b count=%0d", cyc, tick, busy, done, count, e_tick, e_busy, e_done, e_count);
      end
    end
    tests_run++;
    if (!seen || busy !== 1'b0 || count !== '0) begin
      tests_failed++;
      $display("FAIL oneshot_expire got done_seen=%0d busy=%b count=%0d required done_seen=1 busy=0 count=0", seen, busy, count);
    end
    nticks = 0;
    for (int i = 0; i < 100 && nticks < 10; i++) begin
      step();
      if (tick === 1'b1) nticks++;
      if (done === 1'b1) ndone++;
      tests_run++;
      if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count} || count !== '0) begin
        tests_failed++;
        $display("FAIL oneshot_idle cyc=%0d got tick=%b busy=%b done=%b count=%0d exp tick=%b busy=%b done=%b count=0", cyc, tick, busy, done, count, e_tick, e_busy, e_done);
      end
    end
    tests_run++;
    if (ndone != 1 || nticks < 10) begin
      tests_failed++;
      $display("FAIL oneshot_done_count got dones=%0d idle_ticks=%0d required dones=1 idle_ticks=10", ndone, nticks);
    end
  endtask

  task automatic test_periodic();
    int last_done;
    int ndone;
    sel = 2'd1;
    repeat (8) step();
    mode = 1'b1; load_val = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    mode = 1'b0;
    last_done = -1;
    ndone = 0;
    for (int i = 0; i < 320; i++) begin
      if (i == 100) load_val = 16'd5;
      step();
      if (done === 1'b1) begin
        ndone++;
        tests_run++;
        if (last_done >= 0 && (cyc - last_done) != 64) begin
          tests_failed++;
          $display("FAIL periodic_spacing got %0d cycles between dones required 64", cyc - last_done);
        end
        last_done = cyc;
      end
      tests_run++;
      if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count}) begin
        tests_failed++;
        $display("FAIL periodic cyc=%0d got tick=%b busy=%b done=%b count=%0d exp tick=%b busy=%b done=%b count=%0d", cyc, tick, busy, done, count, e_tick, e_busy, e_done, e_count);
      end
    end
    tests_run++;
    if (ndone < 4) begin
      tests_failed++;
      $display("FAIL periodic_dones got %0d dones in 320 cycles required at least 4", ndone);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tests_run++;
      if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count} || busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
        tests_failed++;
        $display("FAIL periodic_stop cyc=%0d got tick=%b busy=%b done=%b count=%0d exp tick=%b busy=0 done=0 count=0", cyc, tick, busy, done, count, e_tick);
      end
      step();
    end
  endtask

  task automatic test_boundaries();
    bit found;
    sel = 2'd0;
    mode = 1'b0; load_val = '0; start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if ({busy, done, count} !== {e_busy, e_done, e_count} || done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_load got busy=%b done=%b count=%0d required busy=0 done=1 count=0", busy, done, count);
    end
    step();
    tests_run++;
    if ({busy, done, count} !== {e_busy, e_done, e_count} || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_load_pulse got busy=%b done=%b count=%0d required busy=0 done=0 count=0", busy, done, count);
    end
    load_val = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (e_tick && e_busy && e_count == 1) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL stop_tick_setup got no tick with count=1 within 100 cycles required one");
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if ({busy, done, count} !== {e_busy, e_done, e_count} || done !== 1'b0 || busy !== 1'b0 || count !== '0) begin
      tests_failed++;
      $display("FAIL stop_with_tick got busy=%b done=%b count=%0d required busy=0 done=0 count=0", busy, done, count);
    end
    load_val = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    load_val = 16'd9; start = 1'b1; mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      tests_run++;
      if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count} || count > 16'd4) begin
        tests_failed++;
        $display("FAIL start_in_run cyc=%0d got busy=%b done=%b count=%0d exp busy=%b done=%b count=%0d", cyc, busy, done, count, e_busy, e_done, e_count);
      end
    end
    start = 1'b0; mode = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_sel_switch();
    bit found;
    bit got_tick;
    sel = 2'd0;
    repeat (6) step();
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      if (div_clk[0] == 1'b0 && div_clk[3] == 1'b1) found = 1'b1;
      else step();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL sel_switch_setup got no window with bit0 low and bit3 high required one");
    end
    sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (tick !== 1'b0 || tick !== e_tick) begin
        tests_failed++;
        $display("FAIL sel_switch_blank cyc=%0d got tick=%b required tick=0", cyc, tick);
      end
    end
    got_tick = 1'b0;
    for (int i = 0; i < 900 && !got_tick; i++) begin
      step();
      if (tick === 1'b1) got_tick = 1'b1;
      tests_run++;
      if (tick !== e_tick) begin
        tests_failed++;
        $display("FAIL sel_switch_next cyc=%0d got tick=%b exp tick=%b", cyc, tick, e_tick);
      end
    end
    tests_run++;
    if (!got_tick) begin
      tests_failed++;
      $display("FAIL sel_switch_timeout got no tick within 900 cycles required one");
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 2; seg++) begin
      use_cnt = (seg == 0);
      for (int i = 0; i < 1500; i++) begin
        start = ($urandom_range(0, 7) == 0);
        stop = ($urandom_range(0, 23) == 0);
        mode = 1'($urandom);
        load_val = WIDTH'($urandom_range(0, 5));
        if ($urandom_range(0, 59) == 0) sel = 2'($urandom);
        step();
        tests_run++;
        if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count}) begin
          tests_failed++;
          $display("FAIL random seg=%0d cyc=%0d got tick=%b busy=%b done=%b count=%0d exp tick=%b busy=%b done=%b count=%0d", seg, cyc, tick, busy, done, count, e_tick, e_busy, e_done, e_count);
        end
      end
    end
    use_cnt = 1'b1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick_timing();
    test_one_shot();
    test_periodic();
    test_boundaries();
    test_sel_switch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
